// File: rtl/cl_bram_pkg.sv
// Shared types and width helpers for the pack/unpack BRAM block.
package cl_bram_pkg;

  // Pack buffer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } pack_state_e;

  // Address width for a power-of-two count; never narrower than one bit.
  function automatic int cl_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Narrow-word host address width: line bits above lane bits.
  function automatic int cl_host_aw(input int lanes, input int depth);
    return cl_clog2(depth) + cl_clog2(lanes);
  endfunction

endpackage

// File: rtl/cl_bram_lane_2p.sv
// Line memory: port A writes with per-lane enables, port B reads a full line
// into a registered output. Contents are never reset.
module cl_bram_lane_2p
  import cl_bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int DEPTH  = 128,
  localparam int AW    = cl_clog2(DEPTH),
  localparam int MEM_W = DATA_W * LANES
) (
  input  logic             clk,
  input  logic [LANES-1:0] a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [MEM_W-1:0] a_wdata,
  input  logic             b_re,
  input  logic [AW-1:0]    b_addr,
  output logic [MEM_W-1:0] b_rdata
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;

    // Lane write, gated by its own enable.
    always_ff @(posedge clk) begin
      if (a_we[l]) mem[a_addr] <= a_wdata[l*DATA_W +: DATA_W];
    end

    // Registered lane read; output holds between reads.
    always_ff @(posedge clk) begin
      if (b_re) q <= mem[b_addr];
    end

    assign b_rdata[l*DATA_W +: DATA_W] = q;
  end

endmodule

// File: rtl/cl_bram_pack_unpack.sv
// Packs narrow host writes into wide memory lines, serves narrow host reads
// (with forwarding from the pack buffer) and full-line array-side reads.
module cl_bram_pack_unpack
  import cl_bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int DEPTH  = 128,
  localparam int MEM_W   = DATA_W * LANES,
  localparam int LINE_AW = cl_clog2(DEPTH),
  localparam int LANE_AW = cl_clog2(LANES),
  localparam int HOST_AW = cl_host_aw(LANES, DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [HOST_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               flush,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic [HOST_AW-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_data_valid,
  input  logic               arr_en,
  input  logic [LINE_AW-1:0] arr_addr,
  output logic [MEM_W-1:0]   arr_rdata,
  output logic               arr_rvalid,
  output logic               busy,
  output logic               err
);

  localparam int RD_LAT = 2;

  pack_state_e                  state_q, state_d;
  logic [LINE_AW-1:0]           buf_line;
  logic [LANES-1:0][DATA_W-1:0] buf_data;
  logic [LANES-1:0]             mask_q, mask_wr;

  logic [LINE_AW-1:0]           wr_line, rd_line;
  logic [LANE_AW-1:0]           wr_lane, rd_lane;
  logic                         wr_acc, rd_acc, fwd_hit;

  logic [RD_LAT-1:0]            vld_pipe;
  logic [LANE_AW-1:0]           s1_lane;
  logic                         s1_fwd;
  logic [DATA_W-1:0]            s1_fwd_data;

  logic [LANES-1:0]             mem_we;
  logic                         mem_re;
  logic [LINE_AW-1:0]           mem_raddr;
  logic [LANES-1:0][DATA_W-1:0] mem_q;
  logic                         mode_q;

  assign wr_line = wr_addr[HOST_AW-1:LANE_AW];
  assign wr_lane = wr_addr[LANE_AW-1:0];
  assign rd_line = rd_addr[HOST_AW-1:LANE_AW];
  assign rd_lane = rd_addr[LANE_AW-1:0];

  assign busy     = (state_q != IDLE);
  assign wr_ready = !mode && (state_q != COMMIT) &&
                    ((state_q == IDLE) || (wr_line == buf_line));
  assign wr_acc   = wr_valid && wr_ready;

  // A read stays outstanding until its response cycle has passed.
  assign rd_ready = !mode && (state_q != COMMIT) && !(|vld_pipe);
  assign rd_acc   = rd_valid && rd_ready;
  assign fwd_hit  = (rd_line == buf_line) && mask_q[rd_lane];

  // Port B is shared: array reads own it in mode 1, host reads in mode 0.
  assign mem_re    = mode ? arr_en : rd_acc;
  assign mem_raddr = mode ? arr_addr : rd_line;
  // Reset aborts a COMMIT in flight, so the write is gated here too.
  assign mem_we    = ((state_q == COMMIT) && !reset) ? mask_q : '0;

  assign arr_rdata = arr_rvalid ? mem_q : '0;

  // Mask as it would look after accepting the current write.
  always_comb begin
    mask_wr          = mask_q;
    mask_wr[wr_lane] = 1'b1;
  end

  // Next-state: fill lanes, commit on full / flush / line change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_acc) state_d = (&mask_wr) ? COMMIT : FILL;
      end
      FILL: begin
        // In array mode the buffer is frozen.
        if (!mode) begin
          if (wr_acc) begin
            if ((&mask_wr) || flush) state_d = COMMIT;
          end else if (flush || (wr_valid && (wr_line != buf_line))) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, mask and pack-buffer storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      buf_line <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == COMMIT) mask_q <= '0;
      else if (wr_acc)       mask_q <= mask_wr;
      if (wr_acc) begin
        buf_line          <= wr_line;
        buf_data[wr_lane] <= wr_data;
      end
    end
  end

  // Host read pipeline: capture lane/forward info, then select response.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe    <= '0;
      rd_data     <= '0;
      s1_lane     <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_acc};
      if (rd_acc) begin
        s1_lane     <= rd_lane;
        s1_fwd      <= fwd_hit;
        s1_fwd_data <= buf_data[rd_lane];
      end
      if (vld_pipe[0]) rd_data <= s1_fwd ? s1_fwd_data : mem_q[s1_lane];
    end
  end

  assign rd_data_valid = vld_pipe[RD_LAT-1];

  // Array-side valid and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      arr_rvalid <= 1'b0;
      err        <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      arr_rvalid <= mode && arr_en;
      mode_q     <= mode;
      if ((busy && (mode != mode_q)) || (flush && mode)) err <= 1'b1;
    end
  end

  cl_bram_lane_2p #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .a_we    (mem_we),
    .a_addr  (buf_line),
    .a_wdata (buf_data),
    .b_re    (mem_re),
    .b_addr  (mem_raddr),
    .b_rdata (mem_q)
  );

endmodule

// File: tb/tb_cl_bram_pack_unpack.sv
// Bench for cl_bram_pack_unpack: directed scenarios plus random traffic
// checked against a transaction-level memory/pack-buffer model.
module tb_cl_bram_pack_unpack;

  localparam int DATA_W  = 32;
  localparam int LANES   = 2;
  localparam int DEPTH   = 128;
  localparam int LINE_AW = 7;
  localparam int HOST_AW = 8;
  localparam int MEM_W   = 64;
  localparam int NWORDS  = DEPTH * LANES;

  logic               clk = 1'b0;
  logic               reset, mode, wr_valid, wr_ready, flush;
  logic               rd_valid, rd_ready, rd_data_valid;
  logic               arr_en, arr_rvalid, busy, err;
  logic [HOST_AW-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0]  wr_data, rd_data;
  logic [LINE_AW-1:0] arr_addr;
  logic [MEM_W-1:0]   arr_rdata;

  int n_chk = 0;
  int n_err = 0;

  // Model: memory by narrow-word address, plus the pending (unwritten) lanes.
  logic [DATA_W-1:0] mmem [NWORDS];
  logic [DATA_W-1:0] mbuf [LANES];
  logic [LANES-1:0]  mmask = '0;
  int                mline = 0;

  always #5 clk = ~clk;

  cl_bram_pack_unpack #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .arr_en(arr_en), .arr_addr(arr_addr), .arr_rdata(arr_rdata), .arr_rvalid(arr_rvalid),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_commit();
    for (int l = 0; l < LANES; l++)
      if (mmask[l]) mmem[mline*LANES + l] = mbuf[l];
    mmask = '0;
  endfunction

  function automatic void m_write(input int a, input logic [DATA_W-1:0] d);
    int line = a / LANES;
    int lane = a % LANES;
    if (mmask != 0 && mline != line) m_commit();
    mline       = line;
    mbuf[lane]  = d;
    mmask[lane] = 1'b1;
    if (&mmask) m_commit();
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input int a);
    if (mmask[a % LANES] && mline == a / LANES) return mbuf[a % LANES];
    return mmem[a];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input int a, input logic [DATA_W-1:0] d, output int stall);
    stall    = 0;
    wr_valid = 1'b1;
    wr_addr  = a[HOST_AW-1:0];
    wr_data  = d;
    #1;
    while (!wr_ready && stall < 50) begin step(); stall++; end
    if (!wr_ready) chk("wr_timeout", 64'd0, 64'd1);
    step();
    wr_valid = 1'b0;
    m_write(a, d);
  endtask

  task automatic host_read(input int a, input string tag);
    logic [DATA_W-1:0] exp;
    int n = 0;
    exp      = m_read(a);
    rd_valid = 1'b1;
    rd_addr  = a[HOST_AW-1:0];
    #1;
    while (!rd_ready && n < 50) begin step(); n++; end
    if (!rd_ready) chk({tag, "_timeout"}, 64'd0, 64'd1);
    step();
    rd_valid = 1'b0;
    chk({tag, "_vld_early"}, 64'(rd_data_valid), 64'd0);
    step();
    chk({tag, "_vld"}, 64'(rd_data_valid), 64'd1);
    chk({tag, "_data"}, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (mmask != 0) m_commit();
  endtask

  task automatic arr_read(input int line, input string tag);
    logic [MEM_W-1:0] exp;
    int n = 0;
    for (int l = 0; l < LANES; l++) exp[l*DATA_W +: DATA_W] = mmem[line*LANES + l];
    while (busy && n < 50) begin step(); n++; end
    if (busy) chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
    mode     = 1'b1;
    arr_en   = 1'b1;
    arr_addr = line[LINE_AW-1:0];
    step();
    arr_en = 1'b0;
    chk({tag, "_vld"}, 64'(arr_rvalid), 64'd1);
    chk({tag, "_data"}, arr_rdata, exp);
    step();
    chk({tag, "_vld_off"}, 64'(arr_rvalid), 64'd0);
    chk({tag, "_data_off"}, arr_rdata, 64'd0);
    mode = 1'b0;
    step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mmask = '0;
  endtask

  initial begin
    int st;
    logic [DATA_W-1:0] old20, old21;
    reset = 1'b1; mode = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    flush = 1'b0; rd_valid = 1'b0; rd_addr = '0; arr_en = 1'b0; arr_addr = '0;
    step(); step(); step();
    reset = 1'b0;
    step();

    // Reset state.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rvld", 64'(rd_data_valid), 64'd0);
    chk("rst_avld", 64'(arr_rvalid), 64'd0);
    chk("rst_rdata", 64'(rd_data), 64'd0);
    chk("rst_ardata", arr_rdata, 64'd0);
    chk("rst_wrdy", 64'(wr_ready), 64'd1);
    chk("rst_rrdy", 64'(rd_ready), 64'd1);

    // Give every memory word a known value.
    for (int a = 0; a < NWORDS; a++) host_write(a, $urandom, st);

    // Full line commits on the next cycle, then array read of the line.
    host_write(4, 32'h11, st);
    chk("fill_busy", 64'(busy), 64'd1);
    host_write(5, 32'h22, st);
    chk("commit_busy", 64'(busy), 64'd1);
    chk("commit_wrdy", 64'(wr_ready), 64'd0);
    step();
    chk("commit_done", 64'(busy), 64'd0);
    arr_read(2, "line2");

    // Partial line flush writes only the masked lane.
    host_write(6, 32'hAA, st);
    do_flush();
    host_read(7, "flush_keep");
    host_read(6, "flush_lane0");

    // Forwarding from the pack buffer while still uncommitted.
    host_write(8, 32'h5, st);
    host_read(8, "fwd");
    chk("fwd_still_fill", 64'(busy), 64'd1);
    host_read(9, "fwd_miss");

    // Line change stalls the write for the commit of the old line.
    host_write(10, 32'hBEEF, st);
    chk("stall_cycles", 64'(st), 64'd2);
    do_flush();
    host_read(8, "stall_line4");
    host_read(10, "stall_line5");

    // Reset in a COMMIT cycle aborts the memory write.
    old20 = mmem[20];
    old21 = mmem[21];
    host_write(20, 32'h1234, st);
    host_write(21, 32'h5678, st);
    chk("rc_in_commit", 64'(busy), 64'd1);
    pulse_reset();
    chk("rc_busy", 64'(busy), 64'd0);
    chk("rc_rvld", 64'(rd_data_valid), 64'd0);
    mmem[20] = old20;
    mmem[21] = old21;
    host_read(20, "rc_old20");
    host_read(21, "rc_old21");

    // Mode change while busy sets a sticky error; buffer frozen in mode 1.
    host_write(12, 32'hCAFE, st);
    mode = 1'b1;
    step();
    chk("err_set", 64'(err), 64'd1);
    step(); step(); step();
    chk("mode1_hold", 64'(busy), 64'd1);
    mode = 1'b0;
    step();
    chk("err_sticky", 64'(err), 64'd1);
    pulse_reset();
    chk("err_cleared", 64'(err), 64'd0);
    host_read(12, "rst_discard");

    // Flush in array mode is a protocol error.
    mode = 1'b1;
    step();
    chk("mode1_idle_noerr", 64'(err), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_mode1_err", 64'(err), 64'd1);
    mode = 1'b0;
    pulse_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 9);
      int a  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, NWORDS-1);
      if (op <= 3)      host_write(a, $urandom, st);
      else if (op <= 7) host_read(a, "rnd_rd");
      else if (op == 8) do_flush();
      else begin
        if (mmask != 0) do_flush();
        arr_read(a / LANES, "rnd_arr");
      end
    end
    chk("final_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
